muldiv_ctrl: RTL and testbench

//   Sequencer for the HI/LO multiply/divide resource behind alu_op[15:12] (mult/multu/div/divu).

---
 rtl/muldiv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step restoring divider, iterative or fast multiplier.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for mult/multu.
module muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;
    logic [31:0]   opb;
    logic          is_div, neg_q, neg_r;

    logic          op_legal, op_mul, op_signed, accept;
    logic [31:0]   abs1, abs2;
    logic [63:0]   acc_step, div_step, wb_val;

    // Only a single one-hot opcode is a legal request.
    always_comb begin
        op_legal = 1'b0;
        case (req_op)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    assign op_mul    = req_op[0] | req_op[1];
    assign op_signed = req_op[0] | req_op[2];
    assign accept    = req_valid & (state == IDLE) & op_legal & ~flush;
    assign abs1      = (op_signed & src1[31]) ? (~src1 + 32'd1) : src1;
    assign abs2      = (op_signed & src2[31]) ? (~src2 + 32'd1) : src2;

    // Restoring divide: acc = {rem, quot}; the shifted-in remainder needs 33 bits.
    logic [32:0] trial;
    logic        ge;
    logic [31:0] sub;
    assign trial    = acc[63:31];
    assign ge       = trial >= {1'b0, opb};
    assign sub      = trial[31:0] - opb;
    assign div_step = ge ? {sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fa, fb;
    logic signed [63:0] fast_prod;
    assign fa        = {req_op[0] & src1[31], src1};
    assign fb        = {req_op[0] & src2[31], src2};
    assign fast_prod = 64'(fa) * 64'(fb);
    assign acc_step  = div_step;
`else
    // Shift-add: acc = {partial, multiplier}; multiplicand lives in opb.
    logic [32:0] msum;
    logic [63:0] mul_step;
    assign msum     = {1'b0, acc[63:32]} + {1'b0, opb};
    assign mul_step = acc[0] ? {msum, acc[31:1]} : {1'b0, acc[63:1]};
    assign acc_step = is_div ? div_step : mul_step;
`endif

    always_comb begin
        wb_val = acc;
        if (is_div) begin
            wb_val[63:32] = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
            wb_val[31:0]  = neg_q ? (~acc[31:0] + 32'd1)  : acc[31:0];
        end else if (neg_q) begin
            wb_val = ~acc + 64'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op_mul ? WB : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (cnt == CW'(ITER - 1)) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == WB) & ~flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (mthi_we) hi <= mt_data;
                    if (mtlo_we) lo <= mt_data;
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= ~op_mul;
                        neg_q  <= op_signed & (src1[31] ^ src2[31]);
                        neg_r  <= req_op[2] & src1[31];
                        if (op_mul) begin
                            acc <= {32'd0, abs2};
                            opb <= abs1;
                        end else begin
                            acc <= {32'd0, abs1};
                            opb <= abs2;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (op_mul) begin
                            acc   <= fast_prod;
                            neg_q <= 1'b0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                WB: begin
                    if (!flush) begin
                        hi <= wb_val[63:32];
                        lo <= wb_val[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, randomized ops against an arithmetic model,
// and hand-written flush/reset/mthi/mtlo sequences.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] src1, src2;
    logic        req_ready, busy, done;
    logic        flush;
    logic        mthi_we, mtlo_we;
    logic [31:0] mt_data;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    localparam logic [3:0] OP_MULT = 4'b0001, OP_MULTU = 4'b0010,
                           OP_DIV  = 4'b0100, OP_DIVU  = 4'b1000;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .src1(src1), .src2(src2), .req_ready(req_ready), .busy(busy), .done(done),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && (mthi_we || mtlo_we)) begin
            miscompares++;
            $display("FAIL mt_while_busy: bench drove mthi/mtlo while busy");
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result {HI,LO} from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        ref_model = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  ref_model = sa * sb;
            OP_MULTU: ref_model = ua * ub;
            OP_DIV: begin
                if (b == 0) ref_model = {a, a[31] ? 32'd1 : 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_model = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) ref_model = {a, 32'hFFFF_FFFF};
                else ref_model = {(ua % ub) , 32'd0} | (ua / ub);
            end
            default: ref_model = '0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] op);
`ifdef MULDIV_FAST_MUL_EN
        exp_latency = (op[0] | op[1]) ? 1 : 33;
`else
        exp_latency = 33;
`endif
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        check({nm, " ready_before"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd0; src1 = $urandom; src2 = $urandom;
        check({nm, " busy"}, busy, 1);
        lat = 0; got = 0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; lat = i; end
        end
        check({nm, " latency"}, lat, exp_latency(op));
        @(posedge clk); #1;
        check({nm, " hi"}, hi, exp_hi);
        check({nm, " lo"}, lo, exp_lo);
        check({nm, " ready_after"}, req_ready, 1);
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        mthi_we = whi; mtlo_we = wlo; mt_data = d;
        @(posedge clk); #1;
        mthi_we = 1'b0; mtlo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       pick_operand = 32'd0;
            1:       pick_operand = 32'h8000_0000;
            2:       pick_operand = 32'hFFFF_FFFF;
            3:       pick_operand = $urandom_range(0, 20);
            default: pick_operand = $urandom;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
    } vec_t;

    initial begin
        vec_t tbl[9];
        logic [3:0] ops[4];
        logic [63:0] e;
        int dc;

        tbl[0] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        tbl[1] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[2] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[3] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[4] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE};
        tbl[5] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        tbl[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'd1};
        tbl[7] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        tbl[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

        reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; src1 = '0; src2 = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ready", req_ready, 1);

        write_hilo(1'b1, 1'b0, 32'h1234);
        check("mthi hi", hi, 32'h1234);
        check("mthi lo untouched", lo, 0);
        write_hilo(1'b0, 1'b1, 32'h5678);
        check("mtlo lo", lo, 32'h5678);
        check("mtlo hi untouched", hi, 32'h1234);

        foreach (tbl[i])
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo, $sformatf("tbl%0d", i));

        // Multi-hot opcode must be refused.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0011; src1 = 32'd9; src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd0;
        check("illegal op busy", busy, 0);

        // Flush in RUN at cnt==10.
        write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
        dc = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_run idle", busy, 0);
        check("flush_run ready", req_ready, 1);
        repeat (40) @(negedge clk);
        check("flush_run no done", done_cnt, dc);
        check("flush_run hi", hi, 32'hA5A5_A5A5);
        check("flush_run lo", lo, 32'hA5A5_A5A5);

        // Flush coincident with WB.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd0;
        repeat (32) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_wb done", done, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_wb idle", busy, 0);
        check("flush_wb hi", hi, 32'hA5A5_A5A5);
        check("flush_wb lo", lo, 32'hA5A5_A5A5);

        // Reset mid-divide.
        write_hilo(1'b1, 1'b1, 32'h1111_2222);
        dc = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIV; src1 = 32'hFFFF_0000; src2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid hi", hi, 0);
        check("rst_mid lo", lo, 0);
        check("rst_mid busy", busy, 0);
        repeat (40) @(negedge clk);
        check("rst_mid no done", done_cnt, dc);

        for (int n = 0; n < 30; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 3)];
            a  = pick_operand();
            b  = pick_operand();
            e  = ref_model(op, a, b);
            do_op(op, a, b, e[63:32], e[31:0], $sformatf("rnd%0d op=%b a=%h b=%h", n, op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
